// File: rtl/mms_stream_8num_if.sv
// mms_stream_8num_if: input/output valid-ready streams of the serial max/min selector
interface mms_stream_8num_if #(
  parameter int DATA_W = 8,
  parameter int FRAME_LEN = 8
);
  localparam int IDX_W = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  logic in_valid;
  logic in_ready;
  logic select;
  logic [DATA_W-1:0] number;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] result;
  logic [IDX_W-1:0] result_idx;
  modport master (output in_valid, select, number, out_ready, input in_ready, out_valid, result, result_idx);
  modport slave (input in_valid, select, number, out_ready, output in_ready, out_valid, result, result_idx);
endinterface

// File: rtl/mms_stream_8num.sv
// mms_stream_8num: serial max/min of a FRAME_LEN-number frame with position, over valid/ready streams
module mms_stream_8num #(
  parameter int DATA_W = 8,
  parameter int FRAME_LEN = 8
) (
  input logic clk,
  input logic reset,
  input logic clear,
  mms_stream_8num_if.slave s
);
  localparam int IDX_W = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state_q;
  logic [IDX_W-1:0] count_q, best_idx_q, result_idx_q, idx_d;
  logic [DATA_W-1:0] best_q, result_q, best_d;
  logic mode_q, in_ready_q, out_valid_q;
  logic first, replace, last, in_acc, out_acc;
  assign in_acc = s.in_valid && in_ready_q;
  assign out_acc = out_valid_q && s.out_ready;
  assign s.in_ready = in_ready_q;
  assign s.out_valid = out_valid_q;
  assign s.result = result_q;
  assign s.result_idx = result_idx_q;
  // candidate best after the current sample; ties keep the earlier index
  always_comb begin
    first = state_q == IDLE;
    replace = first || (mode_q ? s.number < best_q : s.number > best_q);
    best_d = replace ? s.number : best_q;
    idx_d = first ? '0 : (replace ? count_q : best_idx_q);
    last = count_q == LAST;
  end
  // frame FSM with registered handshake outputs; result is latched on the final accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      best_q <= '0;
      best_idx_q <= '0;
      result_q <= '0;
      result_idx_q <= '0;
      mode_q <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      count_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (in_acc) begin
      best_q <= best_d;
      best_idx_q <= idx_d;
      count_q <= count_q + IDX_W'(1);
      if (first) mode_q <= s.select;
      if (last) begin
        state_q <= HOLD;
        result_q <= best_d;
        result_idx_q <= idx_d;
        in_ready_q <= 1'b0;
        out_valid_q <= 1'b1;
      end else state_q <= ACCUM;
    end else if (out_acc) begin
      state_q <= IDLE;
      count_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mms_stream_8num.sv
// tb_mms_stream_8num: directed frames checked against a frame-level max/min model every cycle
module tb_mms_stream_8num;
  logic clk, reset, clear;
  int n_cmp = 0, n_bad = 0;
  mms_stream_8num_if #(.DATA_W(8), .FRAME_LEN(8)) ifc ();
  mms_stream_8num_if #(.DATA_W(8), .FRAME_LEN(1)) ifc1 ();
  mms_stream_8num #(.DATA_W(8), .FRAME_LEN(8)) dut (.clk(clk), .reset(reset), .clear(clear), .s(ifc.slave));
  mms_stream_8num #(.DATA_W(8), .FRAME_LEN(1)) dut1 (.clk(clk), .reset(reset), .clear(clear), .s(ifc1.slave));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  // frame-level model: collect accepted numbers, scan for first max/min when the frame completes
  int unsigned fq[$];
  bit started = 0, hold = 0, mode = 0;
  int unsigned m_res = 0, m_idx = 0;
  initial forever begin
    @(posedge clk);
    if (reset) begin
      fq.delete(); hold = 0; m_res = 0; m_idx = 0; started = 1;
    end else if (clear) begin
      fq.delete(); hold = 0;
    end else if (hold) begin
      if (ifc.out_ready) hold = 0;
    end else if (ifc.in_valid) begin
      if (fq.size() == 0) mode = ifc.select;
      fq.push_back(ifc.number);
      if (fq.size() == 8) begin
        m_res = fq[0]; m_idx = 0;
        for (int i = 1; i < 8; i++)
          if (mode ? fq[i] < m_res : fq[i] > m_res) begin m_res = fq[i]; m_idx = i; end
        fq.delete(); hold = 1;
      end
    end
  end
  always @(negedge clk) if (started) begin
    chk("model in_ready", ifc.in_ready, !hold);
    chk("model out_valid", ifc.out_valid, hold);
    chk("model result", ifc.result, m_res);
    chk("model result_idx", ifc.result_idx, m_idx);
  end
  task automatic send(input logic [7:0] n, input logic sel);
    ifc.in_valid = 1; ifc.number = n; ifc.select = sel;
    @(negedge clk);
    ifc.in_valid = 0;
  endtask
  task automatic idle(input int n);
    ifc.in_valid = 0;
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_out(input string nm);
    int k = 0;
    while (!ifc.out_valid && k < 30) begin @(negedge clk); k++; end
    chk({nm, " out_valid"}, ifc.out_valid, 1);
  endtask
  task automatic pin(input string nm, input int r, input int i);
    chk({nm, " result"}, ifc.result, r);
    chk({nm, " idx"}, ifc.result_idx, i);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] t1[8] = '{12, 200, 7, 200, 45, 0, 199, 3};
    logic [7:0] t2[8] = '{90, 17, 255, 17, 0, 64, 0, 8};
    logic [7:0] t5[8] = '{3, 9, 1, 9, 0, 2, 8, 7};
    logic [7:0] t6[8] = '{4, 4, 10, 2, 10, 1, 0, 9};
    reset = 1; clear = 0;
    ifc.in_valid = 0; ifc.number = 0; ifc.select = 0; ifc.out_ready = 1;
    ifc1.in_valid = 0; ifc1.number = 0; ifc1.select = 0; ifc1.out_ready = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("reset in_ready", ifc.in_ready, 1);
    chk("reset out_valid", ifc.out_valid, 0);
    pin("reset", 0, 0);
    for (int i = 0; i < 8; i++) send(t1[i], 0);
    chk("t1 latency out_valid", ifc.out_valid, 1);
    pin("t1 max tie", 200, 1);
    idle(1);
    for (int i = 0; i < 8; i++) send(t2[i], i < 2);
    wait_out("t2");
    pin("t2 min", 0, 4);
    idle(1);
    ifc.out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      send(8'(i + 1), 0);
      if (i == 1 || i == 2 || i == 5) idle(i == 2 ? 2 : 1);
    end
    wait_out("t3");
    for (int k = 0; k < 5; k++) begin
      chk("t3 hold in_ready", ifc.in_ready, 0);
      pin("t3 hold", 8, 7);
      @(negedge clk);
    end
    ifc.out_ready = 1;
    @(negedge clk);
    chk("t3 release in_ready", ifc.in_ready, 1);
    chk("t3 release out_valid", ifc.out_valid, 0);
    for (int i = 0; i < 4; i++) send(8'(100 + i), 0);
    clear = 1; ifc.in_valid = 1; ifc.number = 99;
    @(negedge clk);
    clear = 0; ifc.in_valid = 0;
    chk("t4 clear out_valid", ifc.out_valid, 0);
    for (int i = 0; i < 8; i++) send(5, 1);
    wait_out("t4");
    pin("t4 min all equal", 5, 0);
    idle(1);
    ifc.out_ready = 0;
    for (int i = 0; i < 8; i++) send(t5[i], 0);
    wait_out("t5");
    pin("t5 pre-reset", 9, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("t5 reset out_valid", ifc.out_valid, 0);
    chk("t5 reset in_ready", ifc.in_ready, 1);
    pin("t5 reset", 0, 0);
    ifc.out_ready = 1;
    for (int i = 0; i < 8; i++) send(t6[i], 0);
    wait_out("t5b");
    pin("t5b max", 10, 2);
    idle(2);
    chk("t6 idle in_ready", ifc1.in_ready, 1);
    ifc1.in_valid = 1; ifc1.number = 8'hA5; ifc1.select = 0;
    @(negedge clk);
    ifc1.in_valid = 0;
    chk("t6 out_valid", ifc1.out_valid, 1);
    chk("t6 in_ready", ifc1.in_ready, 0);
    chk("t6 result", ifc1.result, 8'hA5);
    chk("t6 idx", ifc1.result_idx, 0);
    @(negedge clk);
    chk("t6 done out_valid", ifc1.out_valid, 0);
    ifc1.in_valid = 1; ifc1.number = 8'h3C; ifc1.select = 1;
    @(negedge clk);
    ifc1.in_valid = 0;
    chk("t6b result", ifc1.result, 8'h3C);
    chk("t6b out_valid", ifc1.out_valid, 1);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mms_stream_8num.md
Name: mms_stream_8num

Overview:
- Serial counterpart of the 8-number max/min selector.
- Accepts a frame of FRAME_LEN unsigned numbers, one per handshake, on a valid/ready stream.
- Tracks the running maximum (select=0) or minimum (select=1), then presents the winning value and its position within the frame on an output valid/ready stream.
- Sits between a sample source (e.g. pattern FIFO or testbench driver) and a result consumer; replaces the 8-input combinational tree when inputs arrive over time.

Parameters:
- DATA_W, 8, width of each number and of result.
- FRAME_LEN, 8, numbers per frame; legal range 1..256.
- IDX_W, max(1, clog2(FRAME_LEN)), width of result_idx and internal sample counter.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous frame abort; discards any partial or pending frame.
- in_valid  input  1  number is valid this cycle.
- in_ready  output  1  block can accept a number this cycle.
- select  input  1  0 = find maximum, 1 = find minimum; sampled only on the first number of a frame.
- number  input  DATA_W  unsigned input sample.
- out_valid  output  1  result and result_idx are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  DATA_W  max/min of the completed frame.
- result_idx  output  IDX_W  frame position (0-based) of the result.

Behaviour:
- Input accept = in_valid & in_ready. Output accept = out_valid & out_ready.
- FSM states: IDLE, ACCUM, HOLD.
- Reset (reset=1 at a clock edge):
  - state=IDLE, out_valid=0, result=0, result_idx=0, counter=0, latched mode=0.
  - reset has priority over clear and all handshakes.
- IDLE:
  - in_ready=1, out_valid=0.
  - On accept: best<=number, best_idx<=0, mode<=select, count<=1.
  - Next state is HOLD if FRAME_LEN==1, else ACCUM.
- ACCUM:
  - in_ready=1.
  - On accept, compare number against best using the latched mode:
    - mode=0: replace best if number > best (strictly greater).
    - mode=1: replace best if number < best (strictly less).
    - Ties keep the earlier index. This matches the combinational selector's tie rule.
  - On replace: best_idx<=count.
  - count increments by 1 on every accept.
  - When the accepted number is the last one (count==FRAME_LEN-1), next state=HOLD.
  - Changes on select during ACCUM have no effect.
  - Cycles with in_valid=0 leave all state unchanged (bubbles allowed).
- HOLD:
  - in_ready=0, out_valid=1; result=best, result_idx=best_idx.
  - result and result_idx are stable until the output accept.
  - On output accept: next state=IDLE, out_valid=0 next cycle, count<=0.
  - result and result_idx retain their last values after leaving HOLD.
- Latency:
  - out_valid rises on the cycle after the final number is accepted.
  - Minimum frame period is FRAME_LEN+1 cycles: no overlap of HOLD with a new frame's first input.
- clear=1 (and reset=0):
  - In any state: next state=IDLE, count<=0, out_valid<=0.
  - Any pending result is dropped, even if out_ready=1 in the same cycle.
  - An input handshake coinciding with clear is discarded.
- Outputs are registered or decoded from state only; no combinational path from in_valid/number to outputs.
- in_ready and out_valid are never both 1.
- Arithmetic is unsigned compare of DATA_W bits; no width growth.

Test Plan:
- Max frame, select=0, numbers 12,200,7,200,45,0,199,3 back-to-back, out_ready=1 → out_valid one cycle after 8th accept; result=200, result_idx=1 (tie keeps earlier).
- Min frame, select=1 on first sample then toggled to 0 mid-frame, numbers 90,17,255,17,0,64,0,8 → result=0, result_idx=4; the mid-frame select change is ignored.
- Bubbles and backpressure: max frame 1..8 with in_valid low on random cycles, out_ready held 0 for 5 cycles in HOLD → in_ready=0 and result=8, idx=7 stable throughout; IDLE with in_ready=1 one cycle after out_ready rises.
- Clear mid-frame: after 4 samples assert clear, then send full min frame 5,5,5,5,5,5,5,5 → result=5, result_idx=0; no output from the aborted frame.
- Reset in HOLD with out_ready=0 → next cycle out_valid=0, result=0, result_idx=0, in_ready=1; next frame processes normally.
- FRAME_LEN=1 build: single number 0xA5 accepted → out_valid next cycle, result=0xA5, idx=0.
